// File: rtl/mips_cpu_multdiv.sv
// Iterative MIPS multiply/divide unit owning the HI/LO pair.
// Shift-add multiply and restoring divide, one bit per cycle, fixed 34-cycle op.
module mips_cpu_multdiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 6;
  localparam logic [1:0]  IDLE = 2'd0;
  localparam logic [1:0]  RUN  = 2'd1;
  localparam logic [1:0]  FIX  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]  dvsr_q, dvsr_d;
  logic [1:0]    op_q, op_d;
  logic          sign_a_q, sign_a_d;
  logic          sign_b_q, sign_b_d;
  logic          dz_q, dz_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_step;
  logic [W:0]     div_rem_sh, div_trial;
  logic [2*W-1:0] div_step;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   rem_fix, quo_fix;

  // Signed ops run on magnitudes; op[0] marks the signed variants.
  assign mag_a = (op[0] && a[W-1]) ? W'(32'd0 - a) : a;
  assign mag_b = (op[0] && b[W-1]) ? W'(32'd0 - b) : b;

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB then shift right.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, dvsr_q} : (W+1)'(0));
  assign mul_step = {mul_sum, acc_q[W-1:1]};

  // Divide: acc = {remainder, dividend->quotient}; shift left and trial-subtract.
  assign div_rem_sh = acc_q[2*W-1:W-1];
  assign div_trial  = div_rem_sh - {1'b0, dvsr_q};
  assign div_step   = div_trial[W] ? {div_rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                                   : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};

  assign prod_fix = (sign_a_q ^ sign_b_q) ? (2*W)'(64'd0 - acc_q) : acc_q;
  assign rem_fix  = sign_a_q ? W'(32'd0 - acc_q[2*W-1:W]) : acc_q[2*W-1:W];
  assign quo_fix  = dz_q ? {W{1'b1}}
                  : ((sign_a_q ^ sign_b_q) ? W'(32'd0 - acc_q[W-1:0]) : acc_q[W-1:0]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dvsr_d   = dvsr_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = op[1] ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
          dvsr_d   = op[1] ? mag_b : mag_a;
          op_d     = op;
          sign_a_d = op[0] & a[W-1];
          sign_b_d = op[0] & b[W-1];
          dz_d     = op[1] & (b == '0);
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end
      RUN: begin
        acc_d = op_q[1] ? div_step : mul_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvsr_q   <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dvsr_q   <= dvsr_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mips_cpu_multdiv.sv
// Bench for mips_cpu_multdiv: arithmetic reference model plus directed literal checks.
module tb_mips_cpu_multdiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mips_cpu_multdiv dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an op, from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: res = {32'd0, x} * {32'd0, y};
      2'd1: res = 64'(sx * sy);
      2'd2: res = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      default: begin
        if (y == 0) res = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Reference model: result lands 33 edges after acceptance.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_done = 1'b0;
      m_left--;
      if (m_left == 0) begin
        {m_hi, m_lo} = m_pend;
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_pend = ref_result(op, a, b);
        m_left = 33;
        m_busy = 1'b1;
      end else begin
        if (mthi) m_hi = a;
        if (mtlo) m_lo = a;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_hi", hi, m_hi);
      check("model_lo", lo, m_lo);
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_done", 32'(done), 32'(m_done));
    end
  end

  int busy_cnt;

  // Launch one op and wait (bounded) for its done pulse.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    bit got;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D; op = 2'd3;
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    run_op("multu_max", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    check("multu_busy_cycles", 32'(busy_cnt), 32'd33);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    run_op("mult_neg", 2'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("div_neg", 2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_ovf", 2'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run_op("divu_z", 2'd2, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
    check("divu_z_latency", 32'(busy_cnt), 32'd33);
    run_op("div_z_neg", 2'd3, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);
    run_op("mult_pos_neg", 2'd1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2);

    // MTHI then MTLO in idle
    @(negedge clk);
    mthi = 1'b1; a = 32'hAAAA0000;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; a = 32'h5555;
    check("mthi_hi", hi, 32'hAAAA0000);
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'h5555);
    check("mtlo_no_done", 32'(done), 32'd0);

    // MTHI and second start during a MULTU are ignored
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd1000; b = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; mthi = 1'b1; op = 2'd2; a = 32'h12345678; b = 32'd3;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    check("busy_hi_held", hi, 32'hAAAA0000);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check("ignore_hi", hi, 32'd0);
    check("ignore_lo", lo, 32'd1000000);

    // start + mtlo together: move dropped
    @(negedge clk);
    start = 1'b1; mtlo = 1'b1; op = 2'd0; a = 32'd7; b = 32'd3;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    check("start_mtlo_lo", lo, 32'd1000000);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check("start_mtlo_res", lo, 32'd21);

    // Reset mid-DIV aborts with no done pulse
    @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'hFFFFFF00; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    begin
      int pulses = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) pulses++;
      end
      check("abort_no_done", 32'(pulses), 32'd0);
    end
    run_op("multu_after_rst", 2'd0, 32'd3, 32'd4, 32'd0, 32'd12);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
